// File: rtl/control_conv_fsm.sv
// Top-level sequencer for the 1-D convolution engine: loads the X/F memories from two
// write streams, steps the MAC through each output and hands results out on valid/ready.
module control_conv_fsm #(
    parameter int DATA_N      = 8,
    parameter int LG_DATA_N   = 3,
    parameter int FILTER_N    = 4,
    parameter int LG_FILTER_N = 2,
    parameter int LG_CONV_N   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid_x,
    output logic                   s_ready_x,
    input  logic                   s_valid_f,
    output logic                   s_ready_f,
    output logic                   wr_en_x,
    output logic [LG_DATA_N-1:0]   wr_addr_x,
    output logic                   wr_en_f,
    output logic [LG_FILTER_N-1:0] wr_addr_f,
    output logic                   mem_wr_state,
    output logic                   in_compute,
    output logic                   incr_comp_cyc,
    output logic [LG_CONV_N-1:0]   compute_cyc,
    output logic                   en_acc,
    output logic                   acc_first,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last
);
    localparam int CONV_N = DATA_N - FILTER_N + 1;
    localparam logic [LG_DATA_N-1:0]   X_LAST   = LG_DATA_N'(DATA_N - 1);
    localparam logic [LG_FILTER_N-1:0] F_LAST   = LG_FILTER_N'(FILTER_N - 1);
    localparam logic [LG_CONV_N-1:0]   CYC_LAST = LG_CONV_N'(CONV_N - 1);

    typedef enum logic [2:0] {WRITE, COMPUTE, FLUSH, OUTPUT, RELOAD} state_t;

    state_t                 state;
    logic [LG_DATA_N-1:0]   x_cnt;
    logic [LG_FILTER_N-1:0] f_cnt;
    logic [LG_FILTER_N-1:0] tap_cnt;
    logic                   x_full;
    logic                   f_full;
    logic                   x_done;
    logic                   f_done;
    logic                   handshake;

    assign mem_wr_state = (state == WRITE);
    assign in_compute   = (state == COMPUTE);
    assign m_valid      = (state == OUTPUT);

    assign s_ready_x = mem_wr_state & ~x_full;
    assign s_ready_f = mem_wr_state & ~f_full;
    assign wr_en_x   = s_valid_x & s_ready_x;
    assign wr_en_f   = s_valid_f & s_ready_f;
    assign wr_addr_x = x_cnt;
    assign wr_addr_f = f_cnt;

    // Look-ahead fullness so the last writes of both streams can land in one cycle.
    assign x_done = x_full | (wr_en_x & (x_cnt == X_LAST));
    assign f_done = f_full | (wr_en_f & (f_cnt == F_LAST));

    assign m_last        = m_valid & (compute_cyc == CYC_LAST);
    assign handshake     = m_valid & m_ready;
    assign incr_comp_cyc = handshake & ~m_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= WRITE;
            x_cnt       <= '0;
            f_cnt       <= '0;
            tap_cnt     <= '0;
            x_full      <= 1'b0;
            f_full      <= 1'b0;
            compute_cyc <= '0;
            en_acc      <= 1'b0;
            acc_first   <= 1'b0;
        end else begin
            // One-cycle delay matches the synchronous memory read latency.
            en_acc    <= in_compute;
            acc_first <= in_compute & (tap_cnt == '0);
            case (state)
                WRITE: begin
                    if (wr_en_x) begin
                        if (x_cnt == X_LAST) x_full <= 1'b1;
                        else                 x_cnt  <= x_cnt + 1'b1;
                    end
                    if (wr_en_f) begin
                        if (f_cnt == F_LAST) f_full <= 1'b1;
                        else                 f_cnt  <= f_cnt + 1'b1;
                    end
                    if (x_done && f_done) begin
                        state       <= COMPUTE;
                        x_cnt       <= '0;
                        f_cnt       <= '0;
                        x_full      <= 1'b0;
                        f_full      <= 1'b0;
                        tap_cnt     <= '0;
                        compute_cyc <= '0;
                    end
                end
                COMPUTE: begin
                    if (tap_cnt == F_LAST) begin
                        tap_cnt <= '0;
                        state   <= FLUSH;
                    end else begin
                        tap_cnt <= tap_cnt + 1'b1;
                    end
                end
                FLUSH: state <= OUTPUT;
                OUTPUT: begin
                    if (handshake) begin
                        if (m_last) begin
                            compute_cyc <= '0;
                            state       <= WRITE;
                        end else begin
                            compute_cyc <= compute_cyc + 1'b1;
                            state       <= RELOAD;
                        end
                    end
                end
                RELOAD: state <= COMPUTE;
                default: state <= WRITE;
            endcase
        end
    end
endmodule

// File: doc/control_conv_fsm.md
# control_conv_fsm

Top-level sequencer for the 1-D convolution engine. It sits directly upstream of the read-address unit and drives its `mem_wr_state`, `in_compute`, `incr_comp_cyc` and `compute_cyc` inputs. It also generates write enables and addresses for the X and F memories from two valid/ready input streams, and accumulator enables for the MAC datapath. It presents each convolution result on a valid/ready output handshake.

## Interface
- `DATA_N`, 8: number of X samples per job.
- `LG_DATA_N`, 3: width of X addresses.
- `FILTER_N`, 4: number of filter taps.
- `LG_FILTER_N`, 2: width of F addresses and of the tap counter.
- `LG_CONV_N`, 3: width of `compute_cyc`. CONV_N = DATA_N-FILTER_N+1 (5 at defaults).
- `clk`  in  1  single clock; all registers update on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_valid_x` / `s_ready_x`  in/out  1  X write-stream handshake.
- `s_valid_f` / `s_ready_f`  in/out  1  F write-stream handshake.
- `wr_en_x`, `wr_addr_x`  out  1, LG_DATA_N  X memory write strobe and address.
- `wr_en_f`, `wr_addr_f`  out  1, LG_FILTER_N  F memory write strobe and address.
- `mem_wr_state`  out  1  high while in WRITE.
- `in_compute`  out  1  high while in COMPUTE.
- `incr_comp_cyc`  out  1  one-cycle pulse on a non-last output handshake.
- `compute_cyc`  out  LG_CONV_N  index of the current output (0..CONV_N-1).
- `en_acc`  out  1  accumulator enable; `in_compute` delayed by one cycle.
- `acc_first`  out  1  the accumulator loads the product instead of adding; marks the first tap.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  downstream accepts the result.
- `m_last`  out  1  the current result is output CONV_N-1.

## Operation
- States: WRITE, COMPUTE, FLUSH, OUTPUT, RELOAD. Reset state is WRITE. Outputs are a decode of the registered state and counters.
- **WRITE**
  - `s_ready_x` = !x_full. `wr_en_x` = `s_valid_x` & `s_ready_x`. `wr_addr_x` = x_cnt, which increments on each write.
  - F side is identical, using f_cnt and f_full.
  - x_full sets on write DATA_N-1; f_full sets on write FILTER_N-1. Counters never wrap past the last address.
  - X and F writes may occur in the same cycle, in any order, with gaps.
  - `s_valid` while full is ignored: no strobe, no counter change.
  - WRITE exits to COMPUTE on the edge where both fulls are set, including when both final writes occur in the same cycle.
  - On that exit, x_cnt, f_cnt, the full flags and `compute_cyc` are cleared.
- **COMPUTE**
  - `in_compute`=1 for exactly FILTER_N cycles, with tap_cnt running 0..FILTER_N-1.
  - When tap_cnt reaches FILTER_N-1, the state moves to FLUSH.
- **FLUSH**: lasts 1 cycle, during which the last tap accumulates. Then OUTPUT.
- **OUTPUT**
  - `m_valid`=1 and is held until `m_ready`. `m_ready` is ignored in every other state.
  - `m_last` = (`compute_cyc`==CONV_N-1).
  - On handshake when `m_last`=1: go to WRITE; `compute_cyc` becomes 0.
  - On handshake when `m_last`=0: `incr_comp_cyc`=1 in that same cycle, `compute_cyc` increments at the edge, and the state moves to RELOAD.
- **RELOAD**: lasts 1 cycle with all outputs idle. This lets the read-address unit load `compute_cyc` into its X address. Then COMPUTE.
- **Accumulator controls**
  - `en_acc` is a register of `in_compute`.
  - `acc_first` is a register of (COMPUTE & tap_cnt==0).
  - This alignment matches the 1-cycle synchronous memory read latency.

## Timing
- **Reset values**: state WRITE, so `mem_wr_state`=1 and `s_ready_x`=`s_ready_f`=1.
  - All other outputs are 0: `in_compute`, `incr_comp_cyc`, `en_acc`, `acc_first`, `m_valid`, `m_last`, `wr_en_*`, `wr_addr_*`, `compute_cyc`.
- **Reset mid-operation**
  - All state returns to the reset values immediately (asynchronous).
  - Memory contents are not trusted; a full reload is required.
- **First result**: COMPUTE is entered 1 cycle after the last write. `m_valid` rises FILTER_N+1 cycles after COMPUTE entry.
- **Steady state**: with `m_ready`=1, results arrive every FILTER_N+3 cycles (7 at defaults).
- **Accumulator window**: `en_acc` is high during COMPUTE cycles 1..FILTER_N-1 and in FLUSH. `acc_first` is high on COMPUTE cycle 1 only.
- **`compute_cyc` stability**: it changes only on an OUTPUT handshake edge and is stable throughout backpressure.

## Test plan
- **Full job at defaults**
  - Stimulus: reset, then write x=1..8 and f=1,0,0,0 with `m_ready`=1.
  - Response: 5 results with `compute_cyc` 0..4, `m_last` only on the fifth; return to WRITE with both readies high.
- **Independent streams**
  - Stimulus: load F first with gaps, then X.
  - Response: `wr_addr_f` runs 0..3 and `s_ready_f` drops after the 4th write while `s_ready_x` stays 1.
  - Response: `wr_addr_x` runs 0..7, and COMPUTE is entered 1 cycle after the 8th X write.
- **Simultaneous final writes**
  - Stimulus: final X and F writes in the same cycle.
  - Response: COMPUTE on the next cycle; `in_compute` high exactly 4 cycles.
- **Overrun**
  - Stimulus: hold `s_valid_x`=1 after 8 writes.
  - Response: no `wr_en_x`; `wr_addr_x` stays 7 until the job leaves WRITE.
- **Backpressure**
  - Stimulus: `m_ready`=0 for 3 cycles on output 1.
  - Response: `m_valid` held, `compute_cyc`=1 stable; a single `incr_comp_cyc` pulse in the handshake cycle; `en_acc`/`acc_first` alignment as in Timing.
- **Reset mid-job**
  - Stimulus: assert reset during COMPUTE of output 2.
  - Response: all outputs return to reset values immediately; the next job restarts with `wr_addr` 0 and `compute_cyc` 0.
